// File: rtl/clock_group_reset_pkg.sv
// Shared types and sizing helpers for the clock-group reset sequencer.
// Status outputs are compiled in with CLOCK_GROUP_RESET_SEQ_STATUS_EN.
package clock_group_reset_pkg;

    typedef enum logic [2:0] {
        ASSERT  = 3'd0,
        RELEASE = 3'd1,
        RUN     = 3'd2,
        GATE    = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    localparam int SOFT_COUNT_W = 8;

    function automatic int counter_width(
        input int assert_cycles,
        input int stagger_cycles,
        input int gate_cycles
    );
        int m;
        m = assert_cycles;
        if (stagger_cycles > m) m = stagger_cycles;
        if (gate_cycles > m) m = gate_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clock_group_reset_sequencer_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after STAGES
// clock edges.
module reset_deassert_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    output logic synced_reset
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= (chain << 1) | STAGES'(1);
        end
    end

    assign synced_reset = chain[STAGES-1];

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Power-on and soft-reset sequencer for the clock-group member resets.
// Optional status ports: define CLOCK_GROUP_RESET_SEQ_STATUS_EN.
module clock_group_reset_sequencer
    import clock_group_reset_pkg::*;
#(
    parameter int NUM_MEMBERS    = 6,
    parameter int SYNC_STAGES    = 2,
    parameter int ASSERT_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int GATE_CYCLES    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   soft_req,
    input  logic [NUM_MEMBERS-1:0] soft_mask,
    output logic                   soft_ack,
    output logic [NUM_MEMBERS-1:0] member_reset,
    output logic [NUM_MEMBERS-1:0] member_clock_en,
    output logic                   all_released,
    output logic                   busy
`ifdef CLOCK_GROUP_RESET_SEQ_STATUS_EN
    ,
    output logic [2:0]              seq_state,
    output logic [SOFT_COUNT_W-1:0] soft_count
`endif
);

    if (NUM_MEMBERS < 1 || SYNC_STAGES < 1 || ASSERT_CYCLES < 1 ||
        STAGGER_CYCLES < 1 || GATE_CYCLES < 1) begin : g_param_check
        $error("clock_group_reset_sequencer: parameters must be >= 1");
    end

    localparam int CW =
        counter_width(ASSERT_CYCLES, STAGGER_CYCLES, GATE_CYCLES);
    localparam logic [CW-1:0] ASSERT_N  = CW'(ASSERT_CYCLES);
    localparam logic [CW-1:0] STAGGER_N = CW'(STAGGER_CYCLES);
    localparam logic [CW-1:0] GATE_N    = CW'(GATE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic rst_sync;

    reset_deassert_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clock       (clock),
        .reset       (reset),
        .synced_reset(rst_sync)
    );

    seq_state_t             state, state_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic [NUM_MEMBERS-1:0] target, target_next;
    logic                   armed, armed_next;
    logic                   soft_seq, soft_seq_next;
    logic [NUM_MEMBERS-1:0] reset_next, clock_en_next;
    logic                   ack_next, released_next, busy_next;

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            state           <= ASSERT;
            cnt             <= '0;
            target          <= '1;
            armed           <= 1'b0;
            soft_seq        <= 1'b0;
            member_reset    <= '1;
            member_clock_en <= '1;
            soft_ack        <= 1'b0;
            all_released    <= 1'b0;
            busy            <= 1'b1;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            target          <= target_next;
            armed           <= armed_next;
            soft_seq        <= soft_seq_next;
            member_reset    <= reset_next;
            member_clock_en <= clock_en_next;
            soft_ack        <= ack_next;
            all_released    <= released_next;
            busy            <= busy_next;
        end
    end

    // member_reset doubles as the set of targeted members still held;
    // x & (x - 1) drops the lowest one, so untargeted bits cost no time.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        target_next   = target;
        armed_next    = armed | ~soft_req;
        soft_seq_next = soft_seq;
        reset_next    = member_reset;
        clock_en_next = member_clock_en;
        ack_next      = 1'b0;

        unique case (state)
            ASSERT: begin
                clock_en_next = '1;
                if (cnt == ASSERT_N) begin
                    reset_next = member_reset & (member_reset - 1'b1);
                    cnt_next   = CNT_ONE;
                    state_next = RELEASE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (member_reset == '0) begin
                    state_next = DONE;
                end else if (cnt == STAGGER_N) begin
                    reset_next = member_reset & (member_reset - 1'b1);
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                ack_next      = soft_seq;
                soft_seq_next = 1'b0;
                cnt_next      = '0;
                state_next    = RUN;
            end
            RUN: begin
                if (soft_req && armed) begin
                    target_next = soft_mask;
                    armed_next  = 1'b0;
                    if (soft_mask != '0) begin
                        soft_seq_next = 1'b1;
                        clock_en_next = ~soft_mask;
                        cnt_next      = CNT_ONE;
                        state_next    = GATE;
                    end else begin
                        ack_next = 1'b1;
                    end
                end
            end
            GATE: begin
                if (cnt == GATE_N) begin
                    clock_en_next = '1;
                    reset_next    = target;
                    cnt_next      = CNT_ONE;
                    state_next    = ASSERT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ASSERT;
            end
        endcase

        released_next = (state_next == RUN);
        busy_next     = (state_next != RUN);
    end

`ifdef CLOCK_GROUP_RESET_SEQ_STATUS_EN
    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            soft_count <= '0;
        end else if (ack_next && soft_count != '1) begin
            soft_count <= soft_count + 1'b1;
        end
    end

    assign seq_state = state;
`endif

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed bench for the clock-group reset sequencer, default parameters.
// Edge 0 is the first rising edge with reset high.
module tb_clock_group_reset_sequencer;
    import clock_group_reset_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_req;
    logic [5:0] soft_mask;
    logic       soft_ack;
    logic [5:0] member_reset;
    logic [5:0] member_clock_en;
    logic       all_released;
    logic       busy;
`ifdef CLOCK_GROUP_RESET_SEQ_STATUS_EN
    logic [2:0]              seq_state;
    logic [SOFT_COUNT_W-1:0] soft_count;
`endif

    clock_group_reset_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .soft_req       (soft_req),
        .soft_mask      (soft_mask),
        .soft_ack       (soft_ack),
        .member_reset   (member_reset),
        .member_clock_en(member_clock_en),
        .all_released   (all_released),
        .busy           (busy)
`ifdef CLOCK_GROUP_RESET_SEQ_STATUS_EN
        ,
        .seq_state      (seq_state),
        .soft_count     (soft_count)
`endif
    );

    always #5 clock = ~clock;

    int passed   = 0;
    int total    = 0;
    int edge_idx = -1;
    int ack_cnt  = 0;

    always @(negedge clock) begin
        if (soft_ack === 1'b1) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     tag, got, exp, edge_idx);
        end
    endtask

    task automatic goto(input int k);
        while (edge_idx < k) begin
            @(posedge clock);
            edge_idx++;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset    = 1'b1;
        edge_idx = -1;
    endtask

    task automatic power_on(input bit req_in_assert);
        int a0;
        logic [5:0] e;
        a0 = ack_cnt;
        goto(0);
        check("po_rst0", 32'(member_reset), 32'h3f);
        check("po_busy0", 32'(busy), 32'h1);
        if (req_in_assert) begin
            goto(5);
            soft_req  = 1'b1;
            soft_mask = 6'h01;
        end
        for (int i = 0; i < 6; i++) begin
            goto(17 + 8 * i);
            e = 6'h3f << i;
            check("po_hold", 32'(member_reset), 32'(e));
            goto(18 + 8 * i);
            e = 6'h3f << (i + 1);
            check("po_drop", 32'(member_reset), 32'(e));
            check("po_ce", 32'(member_clock_en), 32'h3f);
        end
        goto(59);
        check("po_rel59", 32'(all_released), 32'h0);
        check("po_busy59", 32'(busy), 32'h1);
        goto(60);
        check("po_rel60", 32'(all_released), 32'h1);
        check("po_busy60", 32'(busy), 32'h0);
        goto(61);
        check("po_noack", 32'(ack_cnt), 32'(a0));
        if (req_in_assert) begin
            check("bi_busy", 32'(busy), 32'h1);
            check("bi_ce", 32'(member_clock_en), 32'h3e);
            check("bi_rel", 32'(all_released), 32'h0);
        end
    endtask

    initial begin
        int a;
        logic [5:0] exp_rst, exp_ce;
        logic       exp_ack, exp_busy;
        reset     = 1'b0;
        soft_req  = 1'b0;
        soft_mask = '0;

        repeat (5) @(posedge clock);
        #1;
        check("rst_mr", 32'(member_reset), 32'h3f);
        check("rst_ce", 32'(member_clock_en), 32'h3f);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_rel", 32'(all_released), 32'h0);
        check("rst_ack", 32'(soft_ack), 32'h0);

        release_reset();
        power_on(1'b0);

        // empty mask: ack next cycle, stay in RUN
        soft_req  = 1'b1;
        soft_mask = 6'h00;
        goto(62);
        check("em_ack", 32'(soft_ack), 32'h1);
        check("em_busy", 32'(busy), 32'h0);
        check("em_mr", 32'(member_reset), 32'h0);
        check("em_ce", 32'(member_clock_en), 32'h3f);
        goto(63);
        check("em_ack_end", 32'(soft_ack), 32'h0);
        soft_req = 1'b0;

        // subset 001010 accepted at edge 66
        goto(65);
        soft_req  = 1'b1;
        soft_mask = 6'b001010;
        for (int k = 66; k <= 97; k++) begin
            goto(k);
            if (k == 66) soft_mask = 6'h3f;
            exp_ce   = (k <= 69) ? 6'h35 : 6'h3f;
            exp_rst  = (k <= 69) ? 6'h00 :
                       (k <= 85) ? 6'h0a :
                       (k <= 93) ? 6'h08 : 6'h00;
            exp_ack  = (k == 96);
            exp_busy = (k <= 95);
            check("ss_mr", 32'(member_reset), 32'(exp_rst));
            check("ss_ce", 32'(member_clock_en), 32'(exp_ce));
            check("ss_ack", 32'(soft_ack), 32'(exp_ack));
            check("ss_busy", 32'(busy), 32'(exp_busy));
        end

        // request held high after ack does not retrigger
        a = ack_cnt;
        for (int j = 1; j <= 50; j++) begin
            goto(97 + j);
            check("ra_busy", 32'(busy), 32'h0);
        end
        check("ra_noack", 32'(ack_cnt), 32'(a));
        soft_req = 1'b0;
        goto(148);
        soft_req  = 1'b1;
        soft_mask = 6'b100000;
        goto(149);
        check("ra_busy_new", 32'(busy), 32'h1);
        check("ra_ce_new", 32'(member_clock_en), 32'h1f);
        goto(180);
        check("ra_ack_new", 32'(ack_cnt), 32'(a + 1));
        check("ra_mr_new", 32'(member_reset), 32'h0);
        soft_req  = 1'b0;
        soft_mask = '0;

        // fresh power-on, then reset mid-RELEASE
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        release_reset();
        goto(34);
        check("mr_before", 32'(member_reset), 32'h38);
        goto(36);
        #2;
        reset = 1'b0;
        #1;
        check("mr_async_rst", 32'(member_reset), 32'h3f);
        check("mr_async_ce", 32'(member_clock_en), 32'h3f);
        check("mr_async_busy", 32'(busy), 32'h1);
        check("mr_async_rel", 32'(all_released), 32'h0);
        repeat (3) @(negedge clock);
        reset    = 1'b1;
        edge_idx = -1;
        power_on(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
